// File: rtl/rgb_mean_divider_if.sv
// Operand and result bundle between the RGB accumulator and the mean divider.
// master drives the sums and start pulse; slave returns means and status.
interface rgb_mean_divider_if #(
  parameter int unsigned SUM_W = 22,
  parameter int unsigned CNT_W = 14,
  parameter int unsigned OUT_W = 8
);
  logic             one_picture;
  logic [SUM_W-1:0] r_sum;
  logic [SUM_W-1:0] g_sum;
  logic [SUM_W-1:0] b_sum;
  logic [CNT_W-1:0] pixel_num;
  logic [OUT_W-1:0] mean_r;
  logic [OUT_W-1:0] mean_g;
  logic [OUT_W-1:0] mean_b;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic             sat;

  modport master (
    output one_picture, r_sum, g_sum, b_sum, pixel_num,
    input  mean_r, mean_g, mean_b, busy, done, div_zero, sat
  );

  modport slave (
    input  one_picture, r_sum, g_sum, b_sum, pixel_num,
    output mean_r, mean_g, mean_b, busy, done, div_zero, sat
  );
endinterface

// File: rtl/rgb_mean_divider.sv
// Per-frame RGB mean: one restoring shift-subtract divider shared across the
// R, G and B channels in turn, with 8-bit saturating results and a done pulse.
module rgb_mean_divider #(
  parameter int unsigned SUM_W = 22,
  parameter int unsigned CNT_W = 14,
  parameter int unsigned OUT_W = 8
) (
  input logic              clk,
  input logic              reset,
  rgb_mean_divider_if.slave bus
);

  localparam int unsigned BitW = $clog2(SUM_W);

  typedef enum logic [1:0] {StIdle, StDiv, StDone} state_e;

  state_e           state_q, state_d;
  logic [1:0]       ch_q, ch_d;
  logic [BitW-1:0]  bit_q, bit_d;
  logic [CNT_W:0]   rem_q, rem_d;
  logic [SUM_W-1:0] dvd_q, dvd_d;
  logic [SUM_W-1:0] quot_q, quot_d;
  logic [CNT_W-1:0] divisor_q, divisor_d;
  logic [SUM_W-1:0] g_q, g_d;
  logic [SUM_W-1:0] b_q, b_d;
  logic [OUT_W-1:0] res_r_q, res_r_d;
  logic [OUT_W-1:0] res_g_q, res_g_d;
  logic             sat_acc_q, sat_acc_d;
  logic [OUT_W-1:0] mean_r_q, mean_r_d;
  logic [OUT_W-1:0] mean_g_q, mean_g_d;
  logic [OUT_W-1:0] mean_b_q, mean_b_d;
  logic             div_zero_q, div_zero_d;
  logic             sat_q, sat_d;

  logic [CNT_W:0]   rem_shift;
  logic [CNT_W:0]   rem_next;
  logic             rem_ge;
  logic [SUM_W-1:0] quot_full;
  logic             q_over;
  logic [OUT_W-1:0] q_sat;

  // One restoring-division step on the current channel.
  always_comb begin
    rem_shift = {rem_q[CNT_W-1:0], dvd_q[SUM_W-1]};
    rem_ge    = rem_shift >= {1'b0, divisor_q};
    rem_next  = rem_ge ? (rem_shift - {1'b0, divisor_q}) : rem_shift;
    quot_full = {quot_q[SUM_W-2:0], rem_ge};
    q_over    = |quot_full[SUM_W-1:OUT_W];
    q_sat     = q_over ? {OUT_W{1'b1}} : quot_full[OUT_W-1:0];
  end

  always_comb begin
    state_d    = state_q;
    ch_d       = ch_q;
    bit_d      = bit_q;
    rem_d      = rem_q;
    dvd_d      = dvd_q;
    quot_d     = quot_q;
    divisor_d  = divisor_q;
    g_d        = g_q;
    b_d        = b_q;
    res_r_d    = res_r_q;
    res_g_d    = res_g_q;
    sat_acc_d  = sat_acc_q;
    mean_r_d   = mean_r_q;
    mean_g_d   = mean_g_q;
    mean_b_d   = mean_b_q;
    div_zero_d = div_zero_q;
    sat_d      = sat_q;

    unique case (state_q)
      StIdle: begin
        if (bus.one_picture) begin
          dvd_d     = bus.r_sum;
          g_d       = bus.g_sum;
          b_d       = bus.b_sum;
          divisor_d = bus.pixel_num;
          ch_d      = 2'd0;
          bit_d     = BitW'(SUM_W - 1);
          rem_d     = '0;
          quot_d    = '0;
          sat_acc_d = 1'b0;
          state_d   = StDiv;
        end
      end

      StDiv: begin
        if (divisor_q == '0) begin
          // Zero divisor short-circuits the run with full-scale means.
          mean_r_d   = {OUT_W{1'b1}};
          mean_g_d   = {OUT_W{1'b1}};
          mean_b_d   = {OUT_W{1'b1}};
          div_zero_d = 1'b1;
          sat_d      = 1'b0;
          state_d    = StDone;
        end else begin
          rem_d  = rem_next;
          quot_d = quot_full;
          dvd_d  = dvd_q << 1;
          bit_d  = bit_q - 1'b1;
          if (bit_q == '0) begin
            sat_acc_d = sat_acc_q | q_over;
            ch_d      = ch_q + 2'd1;
            bit_d     = BitW'(SUM_W - 1);
            rem_d     = '0;
            quot_d    = '0;
            case (ch_q)
              2'd0: begin
                res_r_d = q_sat;
                dvd_d   = g_q;
              end
              2'd1: begin
                res_g_d = q_sat;
                dvd_d   = b_q;
              end
              default: begin
                mean_r_d   = res_r_q;
                mean_g_d   = res_g_q;
                mean_b_d   = q_sat;
                sat_d      = sat_acc_q | q_over;
                div_zero_d = 1'b0;
                ch_d       = 2'd0;
                state_d    = StDone;
              end
            endcase
          end
        end
      end

      StDone: state_d = StIdle;

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      ch_q       <= '0;
      bit_q      <= '0;
      rem_q      <= '0;
      dvd_q      <= '0;
      quot_q     <= '0;
      divisor_q  <= '0;
      g_q        <= '0;
      b_q        <= '0;
      res_r_q    <= '0;
      res_g_q    <= '0;
      sat_acc_q  <= 1'b0;
      mean_r_q   <= '0;
      mean_g_q   <= '0;
      mean_b_q   <= '0;
      div_zero_q <= 1'b0;
      sat_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ch_q       <= ch_d;
      bit_q      <= bit_d;
      rem_q      <= rem_d;
      dvd_q      <= dvd_d;
      quot_q     <= quot_d;
      divisor_q  <= divisor_d;
      g_q        <= g_d;
      b_q        <= b_d;
      res_r_q    <= res_r_d;
      res_g_q    <= res_g_d;
      sat_acc_q  <= sat_acc_d;
      mean_r_q   <= mean_r_d;
      mean_g_q   <= mean_g_d;
      mean_b_q   <= mean_b_d;
      div_zero_q <= div_zero_d;
      sat_q      <= sat_d;
    end
  end

  assign bus.mean_r   = mean_r_q;
  assign bus.mean_g   = mean_g_q;
  assign bus.mean_b   = mean_b_q;
  assign bus.busy     = (state_q != StIdle);
  assign bus.done     = (state_q == StDone);
  assign bus.div_zero = div_zero_q;
  assign bus.sat      = sat_q;

endmodule

// File: tb/tb_rgb_mean_divider.sv
// Directed-vector bench for rgb_mean_divider: latency, truncation, saturation,
// zero divisor, ignored restarts, mid-run reset and back-to-back runs.
module tb_rgb_mean_divider;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;
  int   edges;
  int   pulses;
  logic [7:0] prev_r = 8'd0;
  logic [7:0] prev_g = 8'd0;
  logic [7:0] prev_b = 8'd0;

  always #5 clk = ~clk;

  rgb_mean_divider_if #(.SUM_W(22), .CNT_W(14), .OUT_W(8)) bus ();

  rgb_mean_divider #(.SUM_W(22), .CNT_W(14), .OUT_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Call #1 after an edge; launches a run at the next edge and waits for done.
  // inj_at: restart pulse attempted after that many edges; rst_at: reset then.
  task automatic run(input int pn, input int r, input int g, input int b,
                     input int inj_at, input int rst_at, output int n);
    bus.pixel_num   = 14'(pn);
    bus.r_sum       = 22'(r);
    bus.g_sum       = 22'(g);
    bus.b_sum       = 22'(b);
    bus.one_picture = 1'b1;
    @(posedge clk);
    #1;
    bus.one_picture = 1'b0;
    check_eq("busy_after_start", 32'(bus.busy), 32'd1);
    n = 0;
    while (1) begin
      @(posedge clk);
      n++;
      #1;
      bus.one_picture = 1'b0;
      if (bus.done) break;
      if (n == 10) begin
        check_eq("hold_mean_r", 32'(bus.mean_r), 32'(prev_r));
        check_eq("hold_mean_g", 32'(bus.mean_g), 32'(prev_g));
        check_eq("hold_mean_b", 32'(bus.mean_b), 32'(prev_b));
      end
      if (n == inj_at) begin
        bus.pixel_num   = 14'd1;
        bus.r_sum       = 22'd999;
        bus.g_sum       = 22'd999;
        bus.b_sum       = 22'd999;
        bus.one_picture = 1'b1;
      end
      if (n == rst_at) begin
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        n = -1;
        break;
      end
      if (n > 200) break;
    end
  endtask

  task automatic check_means(input string tag, input int r, input int g, input int b,
                             input int sat, input int dz);
    check_eq({tag, "_mean_r"}, 32'(bus.mean_r), 32'(r));
    check_eq({tag, "_mean_g"}, 32'(bus.mean_g), 32'(g));
    check_eq({tag, "_mean_b"}, 32'(bus.mean_b), 32'(b));
    check_eq({tag, "_sat"}, 32'(bus.sat), 32'(sat));
    check_eq({tag, "_div_zero"}, 32'(bus.div_zero), 32'(dz));
    prev_r = 8'(r);
    prev_g = 8'(g);
    prev_b = 8'(b);
  endtask

  task automatic count_done(input int cycles, output int cnt);
    cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      if (bus.done) cnt++;
    end
  endtask

  initial begin
    bus.one_picture = 1'b1;
    bus.pixel_num   = '0;
    bus.r_sum       = '0;
    bus.g_sum       = '0;
    bus.b_sum       = '0;
    repeat (3) @(posedge clk);
    #1;
    bus.one_picture = 1'b0;
    reset = 1'b0;
    check_eq("rst_busy", 32'(bus.busy), 32'd0);
    check_eq("rst_done", 32'(bus.done), 32'd0);
    check_means("rst", 0, 0, 0, 0, 0);

    // Plain truncating run.
    run(1200, 300000, 153600, 21599, 0, 0, edges);
    check_eq("a_latency", 32'(edges), 32'd66);
    check_means("a", 250, 128, 17, 0, 0);
    @(posedge clk);
    #1;
    check_eq("a_done_pulse", 32'(bus.done), 32'd0);
    check_eq("a_busy_idle", 32'(bus.busy), 32'd0);

    // Back-to-back start in the first idle cycle; saturating channels.
    run(3, 765, 0, 4194303, 0, 0, edges);
    check_eq("b_latency", 32'(edges), 32'd66);
    check_means("b", 255, 0, 255, 1, 0);
    @(posedge clk);
    #1;

    // Zero divisor.
    run(0, 12345, 678, 9, 0, 0, edges);
    check_eq("z_latency", 32'(edges), 32'd1);
    check_means("z", 255, 255, 255, 0, 1);
    @(posedge clk);
    #1;
    check_eq("z_busy_idle", 32'(bus.busy), 32'd0);
    check_eq("z_done_pulse", 32'(bus.done), 32'd0);

    // Restart pulse mid-run is dropped.
    run(1200, 300000, 153600, 21599, 20, 0, edges);
    check_eq("i_latency", 32'(edges), 32'd66);
    check_means("i", 250, 128, 17, 0, 0);
    count_done(80, pulses);
    check_eq("i_no_extra_done", 32'(pulses), 32'd0);

    // Reset during a run aborts it.
    run(1200, 300000, 153600, 21599, 0, 30, edges);
    check_eq("r_aborted", 32'(edges), 32'hFFFF_FFFF);
    check_eq("r_busy", 32'(bus.busy), 32'd0);
    check_eq("r_done", 32'(bus.done), 32'd0);
    check_means("r", 0, 0, 0, 0, 0);
    count_done(80, pulses);
    check_eq("r_no_done", 32'(pulses), 32'd0);

    // Largest divisor after reset.
    run(16383, 16383 * 200, 0, 16383 * 5, 0, 0, edges);
    check_eq("f_latency", 32'(edges), 32'd66);
    check_means("f", 200, 0, 5, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
